// File: rtl/lcd_pixel_unpack_if.sv
// Pixel stream from the unpacker to the palette/formatter stage.
// master drives pixels; slave returns ready.
interface lcd_pixel_unpack_if #(
    parameter int PIXW = 24
);
    logic            pix_valid;
    logic            pix_ready;
    logic [PIXW-1:0] pix_data;
    logic            pix_first;

    modport master (
        output pix_valid,
        output pix_data,
        output pix_first,
        input  pix_ready
    );

    modport slave (
        input  pix_valid,
        input  pix_data,
        input  pix_first,
        output pix_ready
    );
endinterface

// File: rtl/lcd_pixel_unpack.sv
// LCD pixel unpacker: pops 32-bit words from the LCD FIFO and hands them
// out one pixel per transfer at 1/2/4/8/16/24 bits per pixel.
// Pixel mode and order are latched with each word, so software may change
// them while a word is being drained without corrupting it.
// The datapath is a simple state machine:
//   state      | meaning
//   empty      | hold_valid=0, waiting for a FIFO word
//   draining   | hold_valid=1, idx selects the pixel being offered
module lcd_pixel_unpack #(
    parameter int PIXW = 24
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic                      en,
    input  logic [2:0]                bpp,
    input  logic                      bepo,
    input  logic                      flush,
    input  logic                      fifoempty,
    input  logic [31:0]               rdata,
    output logic                      pull,
    output logic                      underflow,
    lcd_pixel_unpack_if.master        pix
);

    logic [31:0] hold;
    logic        hold_valid;
    logic [4:0]  idx;
    logic [2:0]  mode_q;
    logic        bepo_q;
    logic        armed;

    logic        wide_mode;
    logic [4:0]  last_idx;
    logic [4:0]  width_m1;
    logic [23:0] pix_mask;
    logic [4:0]  lsb_pos;
    logic [4:0]  shift;
    logic [23:0] pix_sel;
    logic        accept;
    logic        last;
    logic        uf_set;

    // Modes 6 and 7 fall back to 24bpp: one pixel per word from bits 23:0.
    assign wide_mode = (mode_q >= 3'd5);

    // Per-mode pixel width (minus one), mask and index of the word's last pixel.
    always_comb begin
        last_idx = 5'd0;
        width_m1 = 5'd0;
        pix_mask = 24'hFF_FFFF;
        case (mode_q)
            3'd0: begin last_idx = 5'd31; width_m1 = 5'd0;  pix_mask = 24'h00_0001; end
            3'd1: begin last_idx = 5'd15; width_m1 = 5'd1;  pix_mask = 24'h00_0003; end
            3'd2: begin last_idx = 5'd7;  width_m1 = 5'd3;  pix_mask = 24'h00_000F; end
            3'd3: begin last_idx = 5'd3;  width_m1 = 5'd7;  pix_mask = 24'h00_00FF; end
            3'd4: begin last_idx = 5'd1;  width_m1 = 5'd15; pix_mask = 24'h00_FFFF; end
            default: begin
                last_idx = 5'd0;
                width_m1 = 5'd0;
                pix_mask = 24'hFF_FFFF;
            end
        endcase
    end

    // Bit position of the selected pixel's LSB inside the held word.
    // idx never exceeds last_idx, so idx << mode stays below 32.
    always_comb begin
        lsb_pos = wide_mode ? 5'd0 : (idx << mode_q);
        shift   = lsb_pos;
        if (bepo_q && !wide_mode) begin
            // Pixel 0 sits at the top: LSB = 31 - idx*w - (w-1).
            shift = 5'd31 - lsb_pos - width_m1;
        end
        pix_sel = 24'(hold >> shift) & pix_mask;
    end

    assign accept = hold_valid && pix.pix_ready;
    assign last   = accept && (idx == last_idx);

    // A new word may be pulled into an empty holder or on the same edge the
    // final pixel of the current word is taken, giving back-to-back words.
    assign pull   = !flush && en && !fifoempty && (!hold_valid || last);

    assign uf_set = armed && en && pix.pix_ready && !hold_valid && fifoempty;

    assign pix.pix_valid = hold_valid;
    assign pix.pix_first = hold_valid && (idx == 5'd0);
    assign pix.pix_data  = hold_valid ? PIXW'(pix_sel) : '0;

    // Word data register; qualified by hold_valid so it needs no reset.
    always_ff @(posedge HCLK) begin
        if (pull && !HRESET) begin
            hold <= rdata;
        end
    end

    // Control state: reset beats flush, flush beats load/advance.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            hold_valid <= 1'b0;
            idx        <= 5'd0;
            armed      <= 1'b0;
            underflow  <= 1'b0;
            mode_q     <= 3'd5;
            bepo_q     <= 1'b0;
        end else if (flush) begin
            hold_valid <= 1'b0;
            idx        <= 5'd0;
            armed      <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            if (pull) begin
                hold_valid <= 1'b1;
                idx        <= 5'd0;
                mode_q     <= bpp;
                bepo_q     <= bepo;
                armed      <= 1'b1;
            end else if (last) begin
                hold_valid <= 1'b0;
            end else if (accept) begin
                idx <= idx + 5'd1;
            end
            if (uf_set) begin
                underflow <= 1'b1;
            end
        end
    end

    // The FIFO must never be popped while it reports empty.
    always_ff @(posedge HCLK) begin
        if (!HRESET) begin
            assert (!(pull && fifoempty)) else $error("pull asserted with empty FIFO");
        end
    end

endmodule

// File: tb/tb_lcd_pixel_unpack.sv
// Bench for lcd_pixel_unpack: a queue-based FIFO plus a pixel-list reference
// model; directed scenarios followed by a randomized soak.
module tb_lcd_pixel_unpack;

    typedef struct packed {
        logic        f;
        logic [23:0] d;
    } px_t;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        en;
    logic [2:0]  bpp;
    logic        bepo;
    logic        flush;
    logic        fifoempty;
    logic [31:0] rdata;
    logic        pull;
    logic        underflow;

    lcd_pixel_unpack_if #(.PIXW(24)) pix_if ();

    lcd_pixel_unpack #(.PIXW(24)) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .en        (en),
        .bpp       (bpp),
        .bepo      (bepo),
        .flush     (flush),
        .fifoempty (fifoempty),
        .rdata     (rdata),
        .pull      (pull),
        .underflow (underflow),
        .pix       (pix_if)
    );

    always #5 HCLK = ~HCLK;

    logic [27:0] dut_vec;
    assign dut_vec = {pull, pix_if.pix_valid, pix_if.pix_first, underflow, pix_if.pix_data};

    int          nvec = 0;
    int          nerr = 0;
    int          cyc  = 0;
    logic [31:0] fifo_q[$];
    px_t         exp_q[$];
    bit          armed_m;
    bit          uf_m;
    logic [23:0] acc_log[$];
    int          acc_cyc[$];

    task automatic drive_fifo();
        fifoempty = (fifo_q.size() == 0);
        rdata     = (fifo_q.size() != 0) ? fifo_q[0] : $urandom;
    endtask

    task automatic push(input logic [31:0] w);
        fifo_q.push_back(w);
        drive_fifo();
    endtask

    // Reference: list every pixel of a word from the bpp/order rules.
    task automatic expand(input logic [31:0] w, input logic [2:0] m, input logic b);
        int  n;
        int  ppw;
        int  sh;
        px_t e;
        if (m >= 3'd5) begin
            e.f = 1'b1;
            e.d = w[23:0];
            exp_q.push_back(e);
        end else begin
            n   = 1 << m;
            ppw = 32 / n;
            for (int k = 0; k < ppw; k++) begin
                sh  = b ? (32 - (k + 1) * n) : (k * n);
                e.d = 24'((w >> sh) & ((32'd1 << n) - 32'd1));
                e.f = (k == 0);
                exp_q.push_back(e);
            end
        end
    endtask

    function automatic logic [27:0] exp_vec();
        bit hv;
        bit p;
        hv = (exp_q.size() != 0);
        p  = !flush && en && (fifo_q.size() != 0) &&
             (!hv || (pix_if.pix_ready && exp_q.size() == 1));
        return {p, hv, hv ? exp_q[0].f : 1'b0, uf_m, hv ? exp_q[0].d : 24'd0};
    endfunction

    // Advance one clock and move the model along with the same inputs.
    task automatic tick();
        bit          hv;
        bit          acc;
        bit          emp;
        bit          p;
        bit          ufc;
        bit          rst;
        bit          fl;
        logic [2:0]  m;
        logic        b;
        logic [31:0] w;
        hv  = (exp_q.size() != 0);
        acc = hv && pix_if.pix_ready;
        emp = (fifo_q.size() == 0);
        p   = !flush && en && !emp && (!hv || (acc && exp_q.size() == 1));
        ufc = armed_m && en && pix_if.pix_ready && !hv && emp;
        rst = HRESET;
        fl  = flush;
        m   = bpp;
        b   = bepo;
        w   = 32'd0;
        if (pix_if.pix_valid && pix_if.pix_ready) begin
            acc_log.push_back(pix_if.pix_data);
            acc_cyc.push_back(cyc);
        end
        @(posedge HCLK);
        #1;
        cyc++;
        if (fl) fifo_q.delete();
        else if (p) w = fifo_q.pop_front();
        if (rst || fl) begin
            exp_q.delete();
            armed_m = 1'b0;
            uf_m    = 1'b0;
        end else begin
            if (ufc) uf_m = 1'b1;
            if (acc) exp_q.delete(0);
            if (p) begin
                expand(w, m, b);
                armed_m = 1'b1;
            end
        end
        drive_fifo();
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(negedge HCLK);
        tick();
        flush = 1'b0;
        acc_log.delete();
        acc_cyc.delete();
    endtask

    task automatic test_reset();
        HRESET = 1'b1;
        flush  = 1'b1;
        en     = 1'b0;
        bpp    = 3'd2;
        bepo   = 1'b0;
        pix_if.pix_ready = 1'b1;
        drive_fifo();
        @(negedge HCLK);
        tick();
        flush = 1'b0;
        @(negedge HCLK);
        tick();
        HRESET = 1'b0;
        @(negedge HCLK);
        nvec++;
        if (dut_vec !== 28'd0) begin
            nerr++;
            $display("FAIL reset_outputs: got %h want %h", dut_vec, 28'd0);
        end
        nvec++;
        if (dut_vec !== exp_vec()) begin
            nerr++;
            $display("FAIL reset_model: got %h want %h", dut_vec, exp_vec());
        end
        tick();
        en = 1'b1;
    endtask

    task automatic test_4bpp(input logic be);
        logic [23:0] want;
        do_flush();
        bpp  = 3'd2;
        bepo = be;
        pix_if.pix_ready = 1'b1;
        push(32'h8765_4321);
        for (int c = 0; c < 11; c++) begin
            @(negedge HCLK);
            nvec++;
            if (dut_vec !== exp_vec()) begin
                nerr++;
                $display("FAIL 4bpp_be%0d cyc %0d: got %h want %h", be, c, dut_vec, exp_vec());
            end
            tick();
        end
        nvec++;
        if (acc_log.size() != 8) begin
            nerr++;
            $display("FAIL 4bpp_be%0d_count: got %0d want 8", be, acc_log.size());
        end
        for (int k = 0; k < 8 && k < acc_log.size(); k++) begin
            want = be ? 24'(8 - k) : 24'(k + 1);
            nvec++;
            if (acc_log[k] !== want) begin
                nerr++;
                $display("FAIL 4bpp_be%0d_pix%0d: got %h want %h", be, k, acc_log[k], want);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [23:0] want[4];
        want[0] = 24'h5555;
        want[1] = 24'hAAAA;
        want[2] = 24'h0FF0;
        want[3] = 24'h1234;
        do_flush();
        bpp  = 3'd4;
        bepo = 1'b0;
        pix_if.pix_ready = 1'b1;
        push(32'hAAAA_5555);
        push(32'h1234_0FF0);
        for (int c = 0; c < 7; c++) begin
            @(negedge HCLK);
            nvec++;
            if (dut_vec !== exp_vec()) begin
                nerr++;
                $display("FAIL b2b_16bpp cyc %0d: got %h want %h", c, dut_vec, exp_vec());
            end
            tick();
        end
        nvec++;
        if (acc_log.size() != 4) begin
            nerr++;
            $display("FAIL b2b_count: got %0d want 4", acc_log.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                nvec++;
                if (acc_log[k] !== want[k]) begin
                    nerr++;
                    $display("FAIL b2b_pix%0d: got %h want %h", k, acc_log[k], want[k]);
                end
            end
            nvec++;
            if (acc_cyc[3] - acc_cyc[0] != 3) begin
                nerr++;
                $display("FAIL b2b_bubble: got span %0d want 3", acc_cyc[3] - acc_cyc[0]);
            end
        end
    endtask

    task automatic test_mode_switch();
        logic [23:0] want[5];
        want[0] = 24'h112233;
        want[1] = 24'h0000D4;
        want[2] = 24'h0000C3;
        want[3] = 24'h0000B2;
        want[4] = 24'h0000A1;
        do_flush();
        bpp  = 3'd5;
        bepo = 1'b1;
        pix_if.pix_ready = 1'b1;
        push(32'hFF11_2233);
        push(32'hA1B2_C3D4);
        for (int c = 0; c < 8; c++) begin
            @(negedge HCLK);
            nvec++;
            if (dut_vec !== exp_vec()) begin
                nerr++;
                $display("FAIL mode_switch cyc %0d: got %h want %h", c, dut_vec, exp_vec());
            end
            tick();
            if (c == 0) begin
                bpp  = 3'd3;
                bepo = 1'b0;
            end
            if (c == 3) begin
                bpp  = 3'd0;
                bepo = 1'b1;
            end
        end
        nvec++;
        if (acc_log.size() != 5) begin
            nerr++;
            $display("FAIL mode_switch_count: got %0d want 5", acc_log.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                nvec++;
                if (acc_log[k] !== want[k]) begin
                    nerr++;
                    $display("FAIL mode_switch_pix%0d: got %h want %h", k, acc_log[k], want[k]);
                end
            end
        end
    endtask

    task automatic test_1bpp_stall();
        do_flush();
        bpp  = 3'd0;
        bepo = 1'b0;
        pix_if.pix_ready = 1'b1;
        push(32'h0000_0001);
        push(32'hFFFF_FFFF);
        for (int c = 0; c < 72; c++) begin
            @(negedge HCLK);
            nvec++;
            if (dut_vec !== exp_vec()) begin
                nerr++;
                $display("FAIL 1bpp_stall cyc %0d: got %h want %h", c, dut_vec, exp_vec());
            end
            tick();
            pix_if.pix_ready = ~pix_if.pix_ready;
        end
        nvec++;
        if (acc_log.size() < 33) begin
            nerr++;
            $display("FAIL 1bpp_count: got %0d want >=33", acc_log.size());
        end else begin
            for (int k = 0; k < 33; k++) begin
                nvec++;
                if (acc_log[k] !== ((k == 0 || k == 32) ? 24'd1 : 24'd0)) begin
                    nerr++;
                    $display("FAIL 1bpp_pix%0d: got %h", k, acc_log[k]);
                end
            end
        end
        pix_if.pix_ready = 1'b1;
    endtask

    task automatic test_underflow_flush();
        do_flush();
        bpp  = 3'd5;
        bepo = 1'b0;
        pix_if.pix_ready = 1'b1;
        push(32'h00C0_FFEE);
        for (int c = 0; c < 6; c++) begin
            @(negedge HCLK);
            nvec++;
            if (dut_vec !== exp_vec()) begin
                nerr++;
                $display("FAIL underflow cyc %0d: got %h want %h", c, dut_vec, exp_vec());
            end
            tick();
        end
        nvec++;
        if (underflow !== 1'b1) begin
            nerr++;
            $display("FAIL underflow_sticky: got %b want 1", underflow);
        end
        push(32'h1111_2222);
        flush = 1'b1;
        @(negedge HCLK);
        nvec++;
        if (pull !== 1'b0) begin
            nerr++;
            $display("FAIL flush_nopull: got %b want 0", pull);
        end
        tick();
        flush = 1'b0;
        @(negedge HCLK);
        nvec++;
        if ({underflow, pix_if.pix_valid} !== 2'b00) begin
            nerr++;
            $display("FAIL flush_clear: got uf=%b valid=%b want 0 0", underflow, pix_if.pix_valid);
        end
        tick();
    endtask

    task automatic test_random();
        do_flush();
        for (int c = 0; c < 3000; c++) begin
            bpp              = 3'($urandom_range(0, 7));
            bepo             = 1'($urandom_range(0, 1));
            pix_if.pix_ready = ($urandom_range(0, 3) != 0);
            en               = ($urandom_range(0, 7) != 0);
            flush            = ($urandom_range(0, 63) == 0);
            HRESET           = ($urandom_range(0, 255) == 0);
            if (fifo_q.size() < 4 && $urandom_range(0, 1) == 1) push($urandom);
            @(negedge HCLK);
            nvec++;
            if (dut_vec !== exp_vec()) begin
                nerr++;
                $display("FAIL random cyc %0d: got %h want %h", c, dut_vec, exp_vec());
            end
            tick();
        end
        HRESET = 1'b0;
        flush  = 1'b0;
        en     = 1'b1;
    endtask

    initial begin
        HRESET = 1'b1;
        en     = 1'b0;
        bpp    = 3'd0;
        bepo   = 1'b0;
        flush  = 1'b0;
        pix_if.pix_ready = 1'b0;
        drive_fifo();
        test_reset();
        test_4bpp(1'b0);
        test_4bpp(1'b1);
        test_back_to_back();
        test_mode_switch();
        test_1bpp_stall();
        test_underflow_flush();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/lcd_pixel_unpack.md
Name: lcd_pixel_unpack

Overview:
Downstream consumer of the LCD FIFO. Pulls 32-bit words from the FIFO and splits each word into pixels according to the programmed bits-per-pixel (bpp) mode and pixel order. Presents one pixel per transfer on a valid/ready interface to the palette/formatter stage. Flags sticky underflow when the panel side starves.

Parameters:
PIXW, 24, output pixel width; narrower pixels are zero-extended.

Ports:
HCLK  in  1  clock; all state updates on its rising edge
HRESET  in  1  synchronous, active-high reset
en  in  1  unpack enable; 0 blocks new FIFO pulls
bpp  in  3  0=1bpp, 1=2bpp, 2=4bpp, 3=8bpp, 4=16bpp, 5=24bpp (one pixel per word, bits 23:0); 6/7 behave as 5
bepo  in  1  0: pixel 0 in word LSBs; 1: pixel 0 in word MSBs (ignored in 24bpp)
flush  in  1  drop the held word and clear state (same flush also drives the FIFO)
fifoempty  in  1  FIFO empty
rdata  in  32  FIFO head word; valid in any cycle fifoempty=0
pull  out  1  FIFO pop strobe
pix_valid  out  1  pixel available
pix_ready  in  1  downstream accepts pixel
pix_data  out  PIXW  current pixel, zero-extended
pix_first  out  1  current pixel is pixel 0 of its word
underflow  out  1  sticky starvation flag

Behaviour:
- Registers: hold[31:0], hold_valid, idx[4:0] (pixel index in word), mode_q[2:0], bepo_q, armed, underflow.
- Reset (HRESET=1 at an edge): hold_valid=0, idx=0, armed=0, underflow=0, mode_q=5, bepo_q=0. Outputs after reset: pull=0, pix_valid=0, pix_data=0, pix_first=0, underflow=0.
- bpp_n = 1<<mode_q for modes 0-4. ppw (pixels per word) = 32/bpp_n for modes 0-4, and 1 for mode 5.
- pix_valid = hold_valid. pix_first = hold_valid && idx==0. pix_data = 0 when !hold_valid.
- pix_data, bepo_q=0: hold[idx*bpp_n +: bpp_n]. bepo_q=1: hold[31-idx*bpp_n -: bpp_n]. Mode 5: hold[23:0].
- Accept = pix_valid && pix_ready. last = accept && idx==ppw-1.
- pull is combinational: pull = !flush && en && !fifoempty && (!hold_valid || last). It is never asserted while fifoempty=1.
- On pull: hold<=rdata, hold_valid<=1, idx<=0, mode_q<=bpp, bepo_q<=bepo, armed<=1.
- Mode sampling: bpp and bepo are captured only at word load. Changes made mid-word take effect from the next word.
- On accept without last: idx<=idx+1.
- On last without pull: hold_valid<=0.
- Latency: a word popped at edge t gives pixel 0 on pix_valid after t. Back-to-back words give zero bubbles when the FIFO is non-empty at last.
- en=0: no new pulls. A word already held drains normally.
- Underflow: set when armed && en && pix_ready && !hold_valid && fifoempty. It stays sticky until flush or reset.
- flush (priority over everything else): pull=0 that cycle; hold_valid<=0, idx<=0, armed<=0, underflow<=0. Any accept in the flush cycle is discarded.
- Simultaneous flush and reset: reset wins; the result is identical to reset.

Test Plan:
- Reset, then push 0x8765_4321 with bpp=2 (4bpp), bepo=0, pix_ready=1 -> pull for 1 cycle; pixels 1,2,3,4,5,6,7,8 on 8 consecutive cycles; pix_first on the first pixel only.
- Same word with bepo=1 -> pixels 8,7,6,5,4,3,2,1.
- bpp=4 (16bpp), FIFO holds 0xAAAA_5555 and 0x1234_0FF0, ready always 1 -> pixels 0x5555, 0xAAAA, 0x0FF0, 0x1234 with no bubble; second pull coincides with the 0xAAAA accept.
- bpp=5, word 0xFF11_2233 -> single pixel 0x112233. Switch bpp to 3 mid-stream -> the next word unpacks as 4 bytes.
- 1bpp word 0x0000_0001, pix_ready toggling 1/0 -> 32 pixels (first =1, rest 0); idx holds while ready=0; next pull only after the 32nd accept.
- After one word, FIFO empty with pix_ready=1 and en=1 -> underflow=1 next cycle and stays set. flush -> underflow=0, pix_valid=0, no pull in the flush cycle.
